// File: rtl/aes_pkg.sv
// Shared AES helpers for the key-schedule blocks: round constants, FSM state
// encoding and GF(2^8) arithmetic used by SubWord and InvMixColumns.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_LAST = 8'h36;

  typedef enum logic [1:0] {IDLE, EMIT, SUB} state_t;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // 0x1B is the only rcon whose predecessor wrapped through the reduction polynomial
  function automatic logic [7:0] inv_xtime_rcon(input logic [7:0] r);
    return (r == 8'h1B) ? 8'h80 : (r >> 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    return {gf_mul(s0, 8'h0E) ^ gf_mul(s1, 8'h0B) ^ gf_mul(s2, 8'h0D) ^ gf_mul(s3, 8'h09),
            gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0E) ^ gf_mul(s2, 8'h0B) ^ gf_mul(s3, 8'h0D),
            gf_mul(s0, 8'h0D) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0E) ^ gf_mul(s3, 8'h0B),
            gf_mul(s0, 8'h0B) ^ gf_mul(s1, 8'h0D) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0E)};
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_sub_word.sv
// One-cycle registered AES SubWord shared with the forward key generator.
// S-box is computed as the GF(2^8) inverse (a^254) followed by the affine map.
module SubWord
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] word_in,
  output logic        valid_out,
  output logic [31:0] word_out
);

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      word_out  <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in)
        word_out <= {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: walks round keys 10 down to 0 from the last round key.
// Optional AES_INVKEY_IMC_EN applies InvMixColumns to rounds 1..9 on the output only.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int KEY_LEN  = 128,
  parameter int WORD_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_LEN-1:0] key_in,
  output logic [KEY_LEN-1:0] round_key,
  output logic [3:0]         round_idx,
  output logic               key_valid,
  input  logic               key_ready,
  output logic               busy,
  output logic               done
);

  state_t                  state, state_nxt;
  logic [KEY_LEN-1:0]      raw_key;
  logic [3:0]              idx;
  logic [7:0]              rcon;
  logic [3*WORD_LEN-1:0]   b_low;
  logic [WORD_LEN-1:0]     a0, a1, a2, a3, b0, b1, b2, b3;
  logic [WORD_LEN-1:0]     sw_out;
  logic                    sw_valid_in, sw_valid_out, handshake;

  assign a0 = raw_key[KEY_LEN-1 -: WORD_LEN];
  assign a1 = raw_key[KEY_LEN-1-WORD_LEN -: WORD_LEN];
  assign a2 = raw_key[KEY_LEN-1-2*WORD_LEN -: WORD_LEN];
  assign a3 = raw_key[WORD_LEN-1:0];

  assign b3 = a3 ^ a2;
  assign b2 = a2 ^ a1;
  assign b1 = a1 ^ a0;
  // a0 is still intact in SUB because raw_key only updates on the SubWord return
  assign b0 = a0 ^ sw_out ^ {rcon, 24'h0};

  assign handshake   = (state == EMIT) && key_ready;
  assign sw_valid_in = handshake && (idx != 4'd0);

  SubWord u_sub_word (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (sw_valid_in),
    .word_in   (rot_word(b3)),
    .valid_out (sw_valid_out),
    .word_out  (sw_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EMIT;
      EMIT:    if (key_ready) state_nxt = (idx == 4'd0) ? IDLE : SUB;
      SUB:     if (sw_valid_out) state_nxt = EMIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_key <= '0;
      idx     <= '0;
      rcon    <= '0;
      b_low   <= '0;
      done    <= 1'b0;
    end else begin
      done <= handshake && (idx == 4'd0);
      if (state == IDLE && start) begin
        raw_key <= key_in;
        idx     <= 4'(AES_NR);
        rcon    <= RCON_LAST;
      end
      if (sw_valid_in) b_low <= {b1, b2, b3};
      if (state == SUB && sw_valid_out) begin
        raw_key <= {b0, b_low};
        idx     <= idx - 4'd1;
        rcon    <= inv_xtime_rcon(rcon);
      end
    end
  end

  assign key_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign round_idx = idx;

`ifdef AES_INVKEY_IMC_EN
  // Equivalent inverse cipher wants mixed keys for the middle rounds only
  always_comb begin
    round_key = raw_key;
    if (idx != 4'd0 && idx != 4'(AES_NR))
      round_key = {inv_mix_column(a0), inv_mix_column(a1),
                   inv_mix_column(a2), inv_mix_column(a3)};
  end
`else
  assign round_key = raw_key;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched using the FIPS-197 A.1 key schedule.
// Also checks stalls, ignored start, mid-walk reset and the internal rcon walk.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         key_ready;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [127:0] raw_tab  [0:10];
  logic [7:0]   rcon_tab [0:10];

  aes_inv_key_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_in    (key_in),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    raw_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    raw_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    raw_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    raw_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    raw_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    raw_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    raw_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    raw_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    raw_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    raw_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    raw_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rcon_tab[0]  = 8'h00;
    rcon_tab[1]  = 8'h01;
    rcon_tab[2]  = 8'h02;
    rcon_tab[3]  = 8'h04;
    rcon_tab[4]  = 8'h08;
    rcon_tab[5]  = 8'h10;
    rcon_tab[6]  = 8'h20;
    rcon_tab[7]  = 8'h40;
    rcon_tab[8]  = 8'h80;
    rcon_tab[9]  = 8'h1B;
    rcon_tab[10] = 8'h36;
  end

  function automatic logic [7:0] tb_x2(input logic [7:0] b);
    logic [7:0] sh;
    sh = {b[6:0], 1'b0};
    return b[7] ? (sh ^ 8'h1B) : sh;
  endfunction

  // Reference InvMixColumns built from doubling chains (9=8+1, 11=8+2+1, 13=8+4+1, 14=8+4+2)
  function automatic logic [127:0] tb_imc(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0]   s[4], m9[4], m11[4], m13[4], m14[4];
    logic [7:0]   d2, d4, d8;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        s[j]   = k[127-32*c-8*j -: 8];
        d2     = tb_x2(s[j]);
        d4     = tb_x2(d2);
        d8     = tb_x2(d4);
        m9[j]  = d8 ^ s[j];
        m11[j] = d8 ^ d2 ^ s[j];
        m13[j] = d8 ^ d4 ^ s[j];
        m14[j] = d8 ^ d4 ^ d2;
      end
      r[127-32*c -: 8]  = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
      r[119-32*c -: 8]  = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
      r[111-32*c -: 8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
      r[103-32*c -: 8]  = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_key(input int r);
`ifdef AES_INVKEY_IMC_EN
    if (r >= 1 && r <= 9) return tb_imc(raw_tab[r]);
`endif
    return raw_tab[r];
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_walk(input int t0);
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.idx = 4'(r);
      e.key = exp_key(r);
      e.cyc = (t0 < 0) ? -1 : t0 + 1 + 2 * (10 - r);
      sb.push_back(e);
    end
  endtask

  // Pulses start for one cycle; key_in is scrambled afterwards to catch late sampling
  task automatic apply_stimulus(input logic [127:0] k, input bit timed, output int t0);
    @(posedge clk);
    #1;
    start  = 1'b1;
    key_in = k;
    t0     = cyc;
    push_walk(timed ? t0 : -1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int t0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        if (t0 >= 0) check_output("done_cycle", 128'(cyc), 128'(t0 + 22));
        check_output("busy_at_done", 128'(busy), 128'd0);
      end
    end
    if (!seen) begin
      check_output("done_timeout", 128'(done), 128'd1);
    end else begin
      @(negedge clk);
      check_output("done_pulse_width", 128'(done), 128'd0);
    end
  endtask

  task automatic wait_round(input logic [3:0] r, output bit found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1 && round_idx == r) found = 1'b1;
    end
    if (!found) check_output("round_wait_timeout", 128'(round_idx), 128'(r));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_round_key"}, round_key, 128'd0);
    check_output({tag, "_round_idx"}, 128'(round_idx), 128'd0);
    check_output({tag, "_key_valid"}, 128'(key_valid), 128'd0);
    check_output({tag, "_busy"}, 128'(busy), 128'd0);
    check_output({tag, "_done"}, 128'(done), 128'd0);
  endtask

  // Monitor: pops on every handshake, verifies hold while stalled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && key_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_key actual_idx=%0d required=none", round_idx);
        end else if (key_ready === 1'b1) begin
          e = sb.pop_front();
          check_output("key", round_key, e.key);
          check_output("idx", 128'(round_idx), 128'(e.idx));
          if (e.cyc >= 0) check_output("key_cycle", 128'(cyc), 128'(e.cyc));
          if (e.idx != 4'd0) check_output("rcon", 128'(dut.rcon), 128'(rcon_tab[e.idx]));
        end else begin
          check_output("hold_key", round_key, sb[0].key);
          check_output("hold_idx", 128'(round_idx), 128'(sb[0].idx));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    bit found;
    reset     = 1'b0;
    start     = 1'b0;
    key_ready = 1'b1;
    key_in    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Continuous walk with exact timing
    apply_stimulus(raw_tab[10], 1'b1, t0);
    wait_done(t0);

    // Back-pressure on round 7 for five cycles
    apply_stimulus(raw_tab[10], 1'b0, t0);
    wait_round(4'd7, found);
    key_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    key_ready = 1'b1;
    wait_done(-1);

    // start with a different key mid-walk must be ignored
    apply_stimulus(raw_tab[10], 1'b0, t0);
    wait_round(4'd5, found);
    start  = 1'b1;
    key_in = 128'h00112233445566778899aabbccddeeff;
    @(posedge clk);
    #1;
    start  = 1'b0;
    wait_done(-1);

    // Reset at round 4 aborts; restart must begin cleanly at round 10
    apply_stimulus(raw_tab[10], 1'b0, t0);
    wait_round(4'd4, found);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    check_output("abort_no_done", 128'(done), 128'd0);
    reset = 1'b1;
    apply_stimulus(raw_tab[10], 1'b1, t0);
    wait_done(t0);

    check_output("scoreboard_drain", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
